// File: rtl/addsub_pkg.sv
// Shared types and defaults for the bit-serial adder/subtractor.
package addsub_pkg;

  typedef enum logic {
    MODE_ADD = 1'b0,
    MODE_SUB = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 5;

endpackage

// File: rtl/addsub_serial_if.sv
// Request/response channel bundle between operand producer, serial add/sub and result consumer.
interface addsub_serial_if
  import addsub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic             valid_i;
  logic             ready_o;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             mode_i;
  logic             valid_o;
  logic             ready_i;
  logic [WIDTH-1:0] result_o;
  logic             carry_o;
  logic             overflow_o;

  modport master (
    output valid_i, a_i, b_i, mode_i, ready_i,
    input  ready_o, valid_o, result_o, carry_o, overflow_o
  );

  modport slave (
    input  valid_i, a_i, b_i, mode_i, ready_i,
    output ready_o, valid_o, result_o, carry_o, overflow_o
  );
endinterface

// File: rtl/addsub_serial_fa_bit.sv
// Single combinational full-adder cell shared by every bit position of the serial datapath.
module fa_bit (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic sum_o,
  output logic cout_o
);
  assign sum_o  = a_i ^ b_i ^ cin_i;
  assign cout_o = (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i);
endmodule

// File: rtl/addsub_serial.sv
// Bit-serial WIDTH-bit add/sub: one full-adder cell walks LSB to MSB over WIDTH cycles.
module addsub_serial
  import addsub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic            clk_i,
  input  logic            reset_i,
  addsub_serial_if.slave  bus
);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             c_q, c_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             fa_sum, fa_cout;
  logic             accept;

  fa_bit u_fa (
    .a_i    (a_q[0]),
    .b_i    (b_q[0]),
    .cin_i  (c_q),
    .sum_o  (fa_sum),
    .cout_o (fa_cout)
  );

  assign bus.ready_o    = (state_q == IDLE) && !reset_i;
  assign bus.valid_o    = (state_q == DONE);
  assign bus.result_o   = res_q;
  assign bus.carry_o    = carry_q;
  assign bus.overflow_o = ovf_q;
  assign accept         = bus.valid_i && bus.ready_o;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          // Subtraction is A + ~B + 1: the +1 enters as the initial carry.
          a_d     = bus.a_i;
          b_d     = (mode_e'(bus.mode_i) == MODE_SUB) ? ~bus.b_i : bus.b_i;
          c_d     = bus.mode_i;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        res_d = {fa_sum, res_q[WIDTH-1:1]};
        c_d   = fa_cout;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          // c_q here is the carry into the MSB.
          carry_d = fa_cout;
          ovf_d   = c_q ^ fa_cout;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_addsub_serial.sv
// Directed plus randomized bench for addsub_serial, checked against an arithmetic reference model.
module tb_addsub_serial;
  import addsub_pkg::*;

  localparam int W = 5;

  logic clk_i = 1'b0;
  logic reset_i;
  int   n_cmp  = 0;
  int   n_fail = 0;

  addsub_serial_if #(.WIDTH(W)) bus ();

  addsub_serial #(.WIDTH(W)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .bus     (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Reference: integer arithmetic on unsigned and signed views of the operands.
  function automatic void model(input int a, input int b, input logic m,
                                output int res, output int cy, output int ov);
    int full, sa, sb, st;
    full = m ? a + ((1 << W) - b) : a + b;
    res  = full % (1 << W);
    cy   = (full >> W) & 1;
    sa   = (a >= (1 << (W - 1))) ? a - (1 << W) : a;
    sb   = (b >= (1 << (W - 1))) ? b - (1 << W) : b;
    st   = m ? sa - sb : sa + sb;
    ov   = (st > (1 << (W - 1)) - 1 || st < -(1 << (W - 1))) ? 1 : 0;
  endfunction

  task automatic run_op(input int a, input int b, input logic m,
                        input bit scramble, input int hold);
    int res, cy, ov, cycles;
    logic [W-1:0] held;
    model(a, b, m, res, cy, ov);
    cycles = 0;
    while (!bus.ready_o && cycles < 20) begin tick(); cycles++; end
    check("ready_before_req", 32'(bus.ready_o), 32'd1);
    bus.valid_i = 1'b1;
    bus.a_i     = W'(a);
    bus.b_i     = W'(b);
    bus.mode_i  = m;
    tick();
    bus.valid_i = 1'b0;
    cycles = 0;
    while (!bus.valid_o && cycles < 20) begin
      check("ready_busy", 32'(bus.ready_o), 32'd0);
      if (scramble) begin
        bus.a_i     = W'($urandom);
        bus.b_i     = W'($urandom);
        bus.mode_i  = 1'($urandom);
        bus.valid_i = 1'($urandom);
      end
      tick();
      cycles++;
    end
    bus.valid_i = 1'b0;
    check("latency", 32'(cycles), 32'(W));
    check("result", 32'(bus.result_o), 32'(res));
    check("carry", 32'(bus.carry_o), 32'(cy));
    check("overflow", 32'(bus.overflow_o), 32'(ov));
    held = bus.result_o;
    for (int i = 0; i < hold; i++) begin
      tick();
      check("bp_valid", 32'(bus.valid_o), 32'd1);
      check("bp_result", 32'(bus.result_o), 32'(held));
      check("bp_ready", 32'(bus.ready_o), 32'd0);
    end
    bus.ready_i = 1'b1;
    tick();
    bus.ready_i = 1'b0;
    check("post_hs_valid", 32'(bus.valid_o), 32'd0);
    check("post_hs_ready", 32'(bus.ready_o), 32'd1);
  endtask

  initial begin
    reset_i     = 1'b1;
    bus.valid_i = 1'b1;
    bus.a_i     = '0;
    bus.b_i     = '0;
    bus.mode_i  = 1'b0;
    bus.ready_i = 1'b0;
    #1;
    check("rst_ready", 32'(bus.ready_o), 32'd0);
    check("rst_valid", 32'(bus.valid_o), 32'd0);
    check("rst_result", 32'(bus.result_o), 32'd0);
    check("rst_carry", 32'(bus.carry_o), 32'd0);
    check("rst_ovf", 32'(bus.overflow_o), 32'd0);
    tick();
    tick();
    check("rst_no_accept", 32'(bus.ready_o), 32'd0);
    bus.valid_i = 1'b0;
    reset_i = 1'b0;
    #1;
    check("rel_ready", 32'(bus.ready_o), 32'd1);
    check("rel_valid", 32'(bus.valid_o), 32'd0);

    run_op(7, 9, MODE_ADD, 1'b0, 0);
    run_op(3, 5, MODE_SUB, 1'b0, 0);
    run_op(31, 1, MODE_ADD, 1'b0, 0);
    run_op(16, 1, MODE_SUB, 1'b0, 0);
    run_op(12, 0, MODE_SUB, 1'b0, 3);
    run_op(10, 21, MODE_ADD, 1'b1, 0);
    run_op(0, 31, MODE_SUB, 1'b1, 1);

    // Abort mid-CALC.
    bus.valid_i = 1'b1;
    bus.a_i     = W'(13);
    bus.b_i     = W'(14);
    bus.mode_i  = 1'b0;
    tick();
    bus.valid_i = 1'b0;
    tick();
    tick();
    reset_i = 1'b1;
    #1;
    check("abort_ready", 32'(bus.ready_o), 32'd0);
    check("abort_valid", 32'(bus.valid_o), 32'd0);
    check("abort_result", 32'(bus.result_o), 32'd0);
    check("abort_carry", 32'(bus.carry_o), 32'd0);
    check("abort_ovf", 32'(bus.overflow_o), 32'd0);
    tick();
    reset_i = 1'b0;
    #1;
    for (int i = 0; i < W + 2; i++) begin
      check("abort_no_rsp", 32'(bus.valid_o), 32'd0);
      check("abort_idle", 32'(bus.ready_o), 32'd1);
      tick();
    end
    run_op(1, 1, MODE_ADD, 1'b0, 0);

    for (int k = 0; k < 40; k++) begin
      run_op(int'($urandom_range(0, (1 << W) - 1)), int'($urandom_range(0, (1 << W) - 1)),
             1'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
